// File: rtl/chunked_subtractor.sv
// chunked_subtractor: 10-bit unsigned subtractor with borrow-in/borrow-out.
// It is built from two 5-bit stages run on consecutive cycles (low half, then
// high half) and has a fixed 4-cycle start-to-done latency.
// Optional feature macro: SUB_SAT_EN. When defined, a result that would wrap
// below zero is clamped to 0. Bout still reports the borrow.
module chunked_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] A,
  input  logic [9:0] B,
  input  logic       Bin,
  output logic       busy,
  output logic       done,
  output logic [9:0] Diff,
  output logic       Bout
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t     state_reg;
  state_t     state_next;

  // Operands captured at start; later input activity cannot disturb them.
  logic [9:0] a_reg;
  logic [9:0] b_reg;
  logic       bin_reg;

  // Working registers for the two halves and the inter-stage borrow.
  logic [4:0] lo_reg;
  logic [4:0] hi_reg;
  logic       borrow_reg;
  logic       final_borrow_reg;
  logic       done_reg;

  // Each stage computes a + ~b + ~borrow_in in 5 bits.
  // The carry out is the inverse of the borrow out.
  logic [5:0] lo_sum;
  logic [5:0] hi_sum;

  assign lo_sum = {1'b0, a_reg[4:0]} + {1'b0, ~b_reg[4:0]} + {5'b0, ~bin_reg};
  assign hi_sum = {1'b0, a_reg[9:5]} + {1'b0, ~b_reg[9:5]} + {5'b0, ~borrow_reg};

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. Start is only looked at in IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LOW;
      LOW:     state_next = HIGH;
      HIGH:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: busy covers every non-idle state.
  always_comb begin
    busy = (state_reg != IDLE);
  end

  // Datapath: latch operands, run the low and high stages, then publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg            <= '0;
      b_reg            <= '0;
      bin_reg          <= 1'b0;
      lo_reg           <= '0;
      hi_reg           <= '0;
      borrow_reg       <= 1'b0;
      final_borrow_reg <= 1'b0;
      done_reg         <= 1'b0;
      Diff             <= '0;
      Bout             <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg   <= A;
            b_reg   <= B;
            bin_reg <= Bin;
          end
        end
        LOW: begin
          lo_reg     <= lo_sum[4:0];
          borrow_reg <= ~lo_sum[5];
        end
        HIGH: begin
          hi_reg           <= hi_sum[4:0];
          final_borrow_reg <= ~hi_sum[5];
        end
        DONE: begin
`ifdef SUB_SAT_EN
          Diff <= final_borrow_reg ? 10'd0 : {hi_reg, lo_reg};
`else
          Diff <= {hi_reg, lo_reg};
`endif
          Bout     <= final_borrow_reg;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done = done_reg;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Bench for chunked_subtractor. The driver pushes expected results into a
// queue, and a separate monitor pops one entry and checks it on every done pulse.
module tb_chunked_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] A;
  logic [9:0] B;
  logic       Bin;
  logic       busy;
  logic       done;
  logic [9:0] Diff;
  logic       Bout;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic [9:0] diff;
    logic       bout;
    int         cyc;
  } exp_t;

  exp_t q[$];

  chunked_subtractor dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer subtraction, wrapped modulo 1024 (or clamped to 0 if saturating).
  function automatic exp_t model(input int a, input int b, input int bi);
    exp_t e;
    int   d;
    d = a - b - bi;
    e.bout = (d < 0);
    if (d < 0) d = d + 1024;
    e.diff = 10'(d);
`ifdef SUB_SAT_EN
    if (e.bout) e.diff = 10'd0;
`endif
    e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got Diff=%0d Bout=%0d at cycle %0d, required no done pulse", Diff, Bout, cyc);
      end else begin
        e = q.pop_front();
        vectors++;
        if (Diff !== e.diff) begin
          miscompares++;
          $display("FAIL diff: got %0d, required %0d", Diff, e.diff);
        end
        vectors++;
        if (Bout !== e.bout) begin
          miscompares++;
          $display("FAIL bout: got %0b, required %0b", Bout, e.bout);
        end
        vectors++;
        if (cyc != e.cyc) begin
          miscompares++;
          $display("FAIL latency: done at cycle %0d, required %0d", cyc, e.cyc);
        end
        $display("op done: Diff=%0d Bout=%0b (exp %0d/%0b)", Diff, Bout, e.diff, e.bout);
      end
    end
  end

  // Issue one start once the DUT is idle. Call this task at a negedge.
  task automatic issue(input logic [9:0] a, input logic [9:0] b, input logic bi, input bit expect_it);
    exp_t e;
    int   n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL busy_timeout: busy=%0b, required 0", busy);
      return;
    end
    A     = a;
    B     = b;
    Bin   = bi;
    start = 1'b1;
    if (expect_it) begin
      e     = model(int'(a), int'(b), int'(bi));
      e.cyc = cyc + 4;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    A     = 10'($urandom);
    B     = 10'($urandom);
    Bin   = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Bin   = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, Diff, Bout} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%0b done=%0b Diff=%0d Bout=%0b, required all 0", busy, done, Diff, Bout);
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(10'd500,  10'd123,  1'b0, 1'b1);
    issue(10'd32,   10'd1,    1'b0, 1'b1);
    issue(10'd5,    10'd300,  1'b0, 1'b1);
    issue(10'd0,    10'd0,    1'b1, 1'b1);
    issue(10'd1023, 10'd0,    1'b0, 1'b1);
    issue(10'd0,    10'd1023, 1'b1, 1'b1);
    issue(10'd31,   10'd31,   1'b1, 1'b1);
    issue(10'd1023, 10'd1023, 1'b0, 1'b1);
    drain();

    // A start pulsed in LOW with different operands must be ignored.
    issue(10'd700, 10'd200, 1'b0, 1'b1);
    A     = 10'd3;
    B     = 10'd900;
    Bin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    drain();

    // A reset asserted in HIGH aborts the operation without a done pulse.
    issue(10'd500, 10'd123, 1'b0, 1'b1);
    drain();
    issue(10'd600, 10'd100, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy, Diff, Bout} !== 12'd0) begin
      miscompares++;
      $display("FAIL abort_state: busy=%0b Diff=%0d Bout=%0b, required all 0", busy, Diff, Bout);
    end
    repeat (8) @(negedge clk);

    // Randomized traffic, including back-to-back starts.
    for (int i = 0; i < 150; i++) begin
      issue(10'($urandom), 10'($urandom), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
